ball_position_updater: RTL and testbench
========================================

BALL_POSITION_UPDATER -- requirements
Module: ball_position_updater

Interface
REQ-001 Parameter SCREEN_WIDTH, default 640, SHALL be the horizontal extent in pixels.
REQ-002 Parameter SCREEN_HEIGHT, default 480, SHALL be the vertical extent in pixels.
REQ-003 Parameter BALL_SIZE, default 10, SHALL be the ball edge length in pixels.
REQ-004 Parameters INIT_X/INIT_Y, defaults 315/235, SHALL be the serve position.
REQ-005 Parameters INIT_VX/INIT_VY, defaults 1/1, SHALL be the serve velocity, 16-bit two's complement.
REQ-006 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-007 Port rst_n, input, 1, SHALL be the reset: synchronous, active-low.
REQ-008 Port frame_tick, input, 1, SHALL be a one-cycle pulse requesting one motion step.
REQ-009 Port serve, input, 1, SHALL be a level request to re-centre the ball.
REQ-010 Ports Vx_in and Vy_in, input, 16 each, SHALL be the signed velocities returned by the collision ALUs.
REQ-011 Port vel_valid, input, 1, SHALL qualify Vx_in and Vy_in.
REQ-012 Port vel_ready, output, 1, SHALL indicate that the block accepts a velocity.
REQ-013 Ports Ball_X and Ball_Y, output, 16 each, SHALL be the registered, unsigned top-left ball position.
REQ-014 Ports Ball_Vx and Ball_Vy, output, 16 each, SHALL be the registered, signed current velocity.
REQ-015 Port pos_valid, output, 1, SHALL pulse for one cycle when a new position is published.
REQ-016 Ports hit_top, hit_bottom, hit_left and hit_right, output, 1 each, SHALL be registered wall-contact flags.
REQ-017 Port frame_overrun, output, 1, SHALL be a sticky flag for a dropped frame_tick.

Function
REQ-018 The FSM SHALL have the states IDLE, MOVE, PUBLISH and WAIT_VEL.
REQ-019 IDLE SHALL go to MOVE when frame_tick=1 and SHALL otherwise stay in IDLE.
REQ-020 MOVE SHALL load the clamped next position and the hit flags, then go to PUBLISH.
REQ-021 PUBLISH SHALL drive pos_valid=1 for exactly one cycle, then go to WAIT_VEL.
REQ-022 WAIT_VEL SHALL drive vel_ready=1.
REQ-023 On vel_valid=1 in WAIT_VEL, the block SHALL load Ball_Vx←Vx_in and Ball_Vy←Vy_in and go to IDLE.
REQ-024 In WAIT_VEL, the block SHALL wait indefinitely while vel_valid=0.
REQ-025 vel_ready SHALL be 0 in every state other than WAIT_VEL.
REQ-026 vel_valid outside WAIT_VEL SHALL be ignored.
REQ-027 Latency: frame_tick high in cycle 0 SHALL give the new Ball_X/Ball_Y and pos_valid=1 in cycle 2, and vel_ready=1 from cycle 3.
REQ-028 Next X SHALL be computed as the 17-bit signed sum of {1'b0,Ball_X} and sign-extended Ball_Vx; next Y SHALL be computed the same way from Ball_Y and Ball_Vy.
REQ-029 Clamp: a sum below 0 SHALL load 0.
REQ-030 Clamp: an X sum above SCREEN_WIDTH-BALL_SIZE SHALL load SCREEN_WIDTH-BALL_SIZE, and a Y sum above SCREEN_HEIGHT-BALL_SIZE SHALL load SCREEN_HEIGHT-BALL_SIZE.
REQ-031 Clamp: any other sum SHALL load unchanged.
REQ-032 Hit flags SHALL be computed from the loaded position in MOVE and held until the next MOVE or serve.
REQ-033 hit_top SHALL be set when Y = SCREEN_HEIGHT-BALL_SIZE.
REQ-034 hit_bottom SHALL be set when Y = 0.
REQ-035 hit_left SHALL be set when X = 0.
REQ-036 hit_right SHALL be set when X = SCREEN_WIDTH-BALL_SIZE.
REQ-037 A zero velocity SHALL leave the position unchanged, and a MOVE/PUBLISH cycle SHALL still occur.
REQ-038 frame_tick=1 in any state other than IDLE SHALL set frame_overrun, SHALL NOT start a step and SHALL NOT be queued.
REQ-039 serve=1 in any state SHALL load INIT_X, INIT_Y, INIT_VX and INIT_VY.
REQ-040 serve=1 SHALL also clear the hit flags and frame_overrun, force the state to IDLE and suppress pos_valid and vel_ready that cycle.
REQ-041 serve SHALL take priority over frame_tick and vel_valid in the same cycle.
REQ-042 rst_n SHALL take priority over serve.

Reset
REQ-043 When rst_n=0 at a clock edge, the block SHALL load state=IDLE, Ball_X=INIT_X, Ball_Y=INIT_Y, Ball_Vx=INIT_VX, Ball_Vy=INIT_VY, all hit flags=0 and frame_overrun=0.
REQ-044 pos_valid and vel_ready SHALL be 0 during reset and in the first cycle after reset.
REQ-045 Reset asserted mid-step (MOVE, PUBLISH or WAIT_VEL) SHALL abandon the step with no pos_valid pulse.

Verification
REQ-046 Bench: reset, then frame_tick at cycle 0 -> Ball_X=316, Ball_Y=236 and pos_valid=1 at cycle 2 only, and vel_ready=1 at cycle 3.
REQ-047 Bench: Ball_Y=468, Vy=+5, then step -> Ball_Y=470 and hit_top=1; then return Vy_in=-5 (0xFFFB) with vel_valid -> Ball_Vy=0xFFFB and next step Ball_Y=465 with hit_top=0.
REQ-048 Bench: Ball_X=3, Vx=-7, then step -> Ball_X=0 and hit_left=1, with no wrap to a large unsigned value.
REQ-049 Bench: hold vel_valid=0 for 20 cycles in WAIT_VEL while pulsing frame_tick -> state stays WAIT_VEL, frame_overrun=1 and the position is unchanged.
REQ-050 Bench: serve=1 together with vel_valid=1 in WAIT_VEL -> INIT values loaded, velocity inputs discarded, state=IDLE and frame_overrun=0.
REQ-051 Bench: rst_n=0 in the PUBLISH cycle -> pos_valid=0 and all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/ball_position_updater.sv
// Ball motion datapath: steps the ball by its velocity once per frame tick,
// clamps to the screen, flags wall contact and hands off to the collision ALUs.
module ball_position_updater #(
  parameter int unsigned SCREEN_WIDTH  = 640,
  parameter int unsigned SCREEN_HEIGHT = 480,
  parameter int unsigned BALL_SIZE     = 10,
  parameter int unsigned INIT_X        = 315,
  parameter int unsigned INIT_Y        = 235,
  parameter logic [15:0] INIT_VX       = 16'h0001,
  parameter logic [15:0] INIT_VY       = 16'h0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        serve,
  input  logic [15:0] Vx_in,
  input  logic [15:0] Vy_in,
  input  logic        vel_valid,
  output logic        vel_ready,
  output logic [15:0] Ball_X,
  output logic [15:0] Ball_Y,
  output logic [15:0] Ball_Vx,
  output logic [15:0] Ball_Vy,
  output logic        pos_valid,
  output logic        hit_top,
  output logic        hit_bottom,
  output logic        hit_left,
  output logic        hit_right,
  output logic        frame_overrun
);

  localparam int unsigned PW = 16;
  localparam int unsigned SW = PW + 1;
  localparam logic [PW-1:0] MAX_X = PW'(SCREEN_WIDTH - BALL_SIZE);
  localparam logic [PW-1:0] MAX_Y = PW'(SCREEN_HEIGHT - BALL_SIZE);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MOVE     = 2'd1,
    PUBLISH  = 2'd2,
    WAIT_VEL = 2'd3
  } state_t;

  state_t state;

  logic [SW-1:0] sum_x;
  logic [SW-1:0] sum_y;
  logic [PW-1:0] next_x;
  logic [PW-1:0] next_y;

  // 17-bit signed sums; bit 16 set means the ball would leave the low edge
  always_comb begin
    sum_x  = {1'b0, Ball_X} + {Ball_Vx[PW-1], Ball_Vx};
    sum_y  = {1'b0, Ball_Y} + {Ball_Vy[PW-1], Ball_Vy};
    next_x = sum_x[PW-1:0];
    next_y = sum_y[PW-1:0];
    if (sum_x[SW-1])
      next_x = '0;
    else if (sum_x > {1'b0, MAX_X})
      next_x = MAX_X;
    if (sum_y[SW-1])
      next_y = '0;
    else if (sum_y > {1'b0, MAX_Y})
      next_y = MAX_Y;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      Ball_X        <= PW'(INIT_X);
      Ball_Y        <= PW'(INIT_Y);
      Ball_Vx       <= INIT_VX;
      Ball_Vy       <= INIT_VY;
      pos_valid     <= 1'b0;
      vel_ready     <= 1'b0;
      hit_top       <= 1'b0;
      hit_bottom    <= 1'b0;
      hit_left      <= 1'b0;
      hit_right     <= 1'b0;
      frame_overrun <= 1'b0;
    end else if (serve) begin
      state         <= IDLE;
      Ball_X        <= PW'(INIT_X);
      Ball_Y        <= PW'(INIT_Y);
      Ball_Vx       <= INIT_VX;
      Ball_Vy       <= INIT_VY;
      pos_valid     <= 1'b0;
      vel_ready     <= 1'b0;
      hit_top       <= 1'b0;
      hit_bottom    <= 1'b0;
      hit_left      <= 1'b0;
      hit_right     <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      pos_valid <= 1'b0;
      vel_ready <= 1'b0;
      // a tick arriving mid-step is dropped, only remembered as an overrun
      if (frame_tick && (state != IDLE))
        frame_overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (frame_tick)
            state <= MOVE;
        end
        MOVE: begin
          Ball_X     <= next_x;
          Ball_Y     <= next_y;
          hit_top    <= (next_y == MAX_Y);
          hit_bottom <= (next_y == '0);
          hit_left   <= (next_x == '0);
          hit_right  <= (next_x == MAX_X);
          pos_valid  <= 1'b1;
          state      <= PUBLISH;
        end
        PUBLISH: begin
          vel_ready <= 1'b1;
          state     <= WAIT_VEL;
        end
        WAIT_VEL: begin
          if (vel_valid) begin
            Ball_Vx <= Vx_in;
            Ball_Vy <= Vy_in;
            state   <= IDLE;
          end else begin
            vel_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_position_updater.sv
// Directed bench for ball_position_updater: latency, clamping, walls,
// velocity handshake stall, serve priority and mid-step reset.
module tb_ball_position_updater;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick;
  logic        serve;
  logic [15:0] Vx_in;
  logic [15:0] Vy_in;
  logic        vel_valid;
  logic        vel_ready;
  logic [15:0] Ball_X;
  logic [15:0] Ball_Y;
  logic [15:0] Ball_Vx;
  logic [15:0] Ball_Vy;
  logic        pos_valid;
  logic        hit_top;
  logic        hit_bottom;
  logic        hit_left;
  logic        hit_right;
  logic        frame_overrun;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ball_position_updater dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .serve(serve),
    .Vx_in(Vx_in), .Vy_in(Vy_in), .vel_valid(vel_valid), .vel_ready(vel_ready),
    .Ball_X(Ball_X), .Ball_Y(Ball_Y), .Ball_Vx(Ball_Vx), .Ball_Vy(Ball_Vy),
    .pos_valid(pos_valid), .hit_top(hit_top), .hit_bottom(hit_bottom),
    .hit_left(hit_left), .hit_right(hit_right), .frame_overrun(frame_overrun)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // leaves the bench in the MOVE cycle
  task automatic pulse_tick();
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
  endtask

  // leaves the bench in the PUBLISH cycle
  task automatic run_step();
    pulse_tick();
    cyc(1);
  endtask

  task automatic give_vel(input logic [15:0] vx, input logic [15:0] vy);
    Vx_in     = vx;
    Vy_in     = vy;
    vel_valid = 1'b1;
    cyc(1);
    vel_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; frame_tick = 1'b0; serve = 1'b0;
    Vx_in = '0; Vy_in = '0; vel_valid = 1'b0;
    cyc(2);
    checks++; if (Ball_X !== 16'd315) begin errors++; $display("FAIL reset_x got %0d want 315", Ball_X); end
    checks++; if (Ball_Y !== 16'd235) begin errors++; $display("FAIL reset_y got %0d want 235", Ball_Y); end
    checks++; if (Ball_Vx !== 16'd1 || Ball_Vy !== 16'd1) begin errors++; $display("FAIL reset_vel got %h/%h want 0001/0001", Ball_Vx, Ball_Vy); end
    checks++; if ({hit_top, hit_bottom, hit_left, hit_right, frame_overrun} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b want 00000", {hit_top, hit_bottom, hit_left, hit_right, frame_overrun}); end
    checks++; if (pos_valid !== 1'b0 || vel_ready !== 1'b0) begin errors++; $display("FAIL reset_hs got %b%b want 00", pos_valid, vel_ready); end
    rst_n = 1'b1;
    cyc(1);
    checks++; if (pos_valid !== 1'b0 || vel_ready !== 1'b0) begin errors++; $display("FAIL post_reset_hs got %b%b want 00", pos_valid, vel_ready); end
  endtask

  task automatic test_latency();
    pulse_tick();
    checks++; if (pos_valid !== 1'b0 || Ball_X !== 16'd315) begin errors++; $display("FAIL lat_c1 got pv=%b x=%0d want pv=0 x=315", pos_valid, Ball_X); end
    cyc(1);
    checks++; if (Ball_X !== 16'd316 || Ball_Y !== 16'd236) begin errors++; $display("FAIL lat_pos got %0d,%0d want 316,236", Ball_X, Ball_Y); end
    checks++; if (pos_valid !== 1'b1 || vel_ready !== 1'b0) begin errors++; $display("FAIL lat_c2 got pv=%b vr=%b want pv=1 vr=0", pos_valid, vel_ready); end
    cyc(1);
    checks++; if (pos_valid !== 1'b0 || vel_ready !== 1'b1) begin errors++; $display("FAIL lat_c3 got pv=%b vr=%b want pv=0 vr=1", pos_valid, vel_ready); end
    give_vel(16'hFEC7, 16'd232);
    checks++; if (Ball_Vx !== 16'hFEC7 || Ball_Vy !== 16'd232) begin errors++; $display("FAIL vel_load got %h/%h want fec7/00e8", Ball_Vx, Ball_Vy); end
    checks++; if (vel_ready !== 1'b0) begin errors++; $display("FAIL vel_ready_drop got %b want 0", vel_ready); end
  endtask

  task automatic test_walls_top_left();
    run_step();
    checks++; if (Ball_X !== 16'd3 || Ball_Y !== 16'd468) begin errors++; $display("FAIL setup_pos got %0d,%0d want 3,468", Ball_X, Ball_Y); end
    cyc(1);
    give_vel(16'd0, 16'd5);
    run_step();
    checks++; if (Ball_Y !== 16'd470 || hit_top !== 1'b1) begin errors++; $display("FAIL top_clamp got y=%0d ht=%b want y=470 ht=1", Ball_Y, hit_top); end
    checks++; if (Ball_X !== 16'd3 || hit_left !== 1'b0) begin errors++; $display("FAIL top_x got x=%0d hl=%b want x=3 hl=0", Ball_X, hit_left); end
    cyc(1);
    give_vel(16'hFFF9, 16'hFFFB);
    checks++; if (Ball_Vy !== 16'hFFFB) begin errors++; $display("FAIL vy_neg got %h want fffb", Ball_Vy); end
    run_step();
    checks++; if (Ball_Y !== 16'd465 || hit_top !== 1'b0) begin errors++; $display("FAIL top_leave got y=%0d ht=%b want y=465 ht=0", Ball_Y, hit_top); end
    checks++; if (Ball_X !== 16'd0 || hit_left !== 1'b1) begin errors++; $display("FAIL left_clamp got x=%0d hl=%b want x=0 hl=1", Ball_X, hit_left); end
  endtask

  task automatic test_zero_velocity();
    cyc(1);
    give_vel(16'd0, 16'd0);
    run_step();
    checks++; if (Ball_X !== 16'd0 || Ball_Y !== 16'd465 || pos_valid !== 1'b1) begin errors++; $display("FAIL zero_vel got %0d,%0d pv=%b want 0,465 pv=1", Ball_X, Ball_Y, pos_valid); end
    checks++; if (hit_left !== 1'b1 || hit_bottom !== 1'b0) begin errors++; $display("FAIL zero_vel_hits got hl=%b hb=%b want 1,0", hit_left, hit_bottom); end
  endtask

  task automatic test_stall();
    logic saw_pv;
    saw_pv = 1'b0;
    cyc(1);
    for (int i = 0; i < 20; i++) begin
      frame_tick = (i % 2 == 0);
      cyc(1);
      if (pos_valid) saw_pv = 1'b1;
    end
    frame_tick = 1'b0;
    checks++; if (vel_ready !== 1'b1) begin errors++; $display("FAIL stall_ready got %b want 1", vel_ready); end
    checks++; if (frame_overrun !== 1'b1) begin errors++; $display("FAIL stall_overrun got %b want 1", frame_overrun); end
    checks++; if (Ball_X !== 16'd0 || Ball_Y !== 16'd465 || saw_pv !== 1'b0) begin errors++; $display("FAIL stall_pos got %0d,%0d pv_seen=%b want 0,465 pv_seen=0", Ball_X, Ball_Y, saw_pv); end
  endtask

  task automatic test_serve();
    Vx_in = 16'h1234; Vy_in = 16'h5678; vel_valid = 1'b1; serve = 1'b1;
    cyc(1);
    serve = 1'b0; vel_valid = 1'b0;
    checks++; if (Ball_X !== 16'd315 || Ball_Y !== 16'd235) begin errors++; $display("FAIL serve_pos got %0d,%0d want 315,235", Ball_X, Ball_Y); end
    checks++; if (Ball_Vx !== 16'd1 || Ball_Vy !== 16'd1) begin errors++; $display("FAIL serve_vel got %h/%h want 0001/0001", Ball_Vx, Ball_Vy); end
    checks++; if (frame_overrun !== 1'b0 || hit_left !== 1'b0) begin errors++; $display("FAIL serve_flags got ov=%b hl=%b want 0,0", frame_overrun, hit_left); end
    checks++; if (vel_ready !== 1'b0 || pos_valid !== 1'b0) begin errors++; $display("FAIL serve_hs got vr=%b pv=%b want 0,0", vel_ready, pos_valid); end
    cyc(1);
    checks++; if (vel_ready !== 1'b0) begin errors++; $display("FAIL serve_idle got vr=%b want 0", vel_ready); end
  endtask

  task automatic test_right_bottom();
    run_step();
    checks++; if (Ball_X !== 16'd316 || Ball_Y !== 16'd236) begin errors++; $display("FAIL post_serve_step got %0d,%0d want 316,236", Ball_X, Ball_Y); end
    cyc(1);
    give_vel(16'd400, 16'hFED4);
    run_step();
    checks++; if (Ball_X !== 16'd630 || hit_right !== 1'b1) begin errors++; $display("FAIL right_clamp got x=%0d hr=%b want x=630 hr=1", Ball_X, hit_right); end
    checks++; if (Ball_Y !== 16'd0 || hit_bottom !== 1'b1) begin errors++; $display("FAIL bottom_clamp got y=%0d hb=%b want y=0 hb=1", Ball_Y, hit_bottom); end
    cyc(1);
    give_vel(16'd0, 16'd0);
  endtask

  task automatic test_reset_mid_step();
    pulse_tick();
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    checks++; if (pos_valid !== 1'b0 || Ball_X !== 16'd315 || hit_right !== 1'b0) begin errors++; $display("FAIL rst_move got pv=%b x=%0d hr=%b want 0,315,0", pos_valid, Ball_X, hit_right); end
    cyc(1);
    run_step();
    checks++; if (pos_valid !== 1'b1 || Ball_X !== 16'd316) begin errors++; $display("FAIL rst_pre_publish got pv=%b x=%0d want 1,316", pos_valid, Ball_X); end
    rst_n = 1'b0;
    cyc(1);
    checks++; if (pos_valid !== 1'b0 || vel_ready !== 1'b0) begin errors++; $display("FAIL rst_publish_hs got pv=%b vr=%b want 0,0", pos_valid, vel_ready); end
    checks++; if (Ball_X !== 16'd315 || Ball_Y !== 16'd235 || Ball_Vx !== 16'd1 || Ball_Vy !== 16'd1) begin errors++; $display("FAIL rst_publish_state got %0d,%0d %h/%h want 315,235 0001/0001", Ball_X, Ball_Y, Ball_Vx, Ball_Vy); end
    checks++; if ({hit_top, hit_bottom, hit_left, hit_right, frame_overrun} !== 5'b0) begin errors++; $display("FAIL rst_publish_flags got %b want 00000", {hit_top, hit_bottom, hit_left, hit_right, frame_overrun}); end
    rst_n = 1'b1;
    cyc(1);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_walls_top_left();
    test_zero_velocity();
    test_stall();
    test_serve();
    test_right_bottom();
    test_reset_mid_step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
